// File: rtl/l1_dcache_pkg.sv
// -----------------------------------------------------------------------------
// l1_dcache_pkg
// Shared definitions for the L1 data cache: FSM state encodings (2-bit),
// the data word width and the statistics counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package l1_dcache_pkg;

    // Controller states
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_REFILL    = 2'd2;

    // CPU data word width in bits
    localparam int WORD_W = 32;

    // Width of the hit/miss statistics counters
    localparam int STAT_W = 32;

endpackage

// File: rtl/l1_dcache_line_store.sv
// -----------------------------------------------------------------------------
// l1_dcache_line_store
// Tag / valid / dirty / data storage for the direct-mapped L1 data cache.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//                           (clears valid and dirty only; tags/data keep state)
//   i_rd_idx                asynchronous read index
//   o_rd_tag/valid/dirty    tag and status of the indexed line
//   o_rd_line               data of the indexed line, word 0 in bits [31:0]
//   i_wr_en/idx/word/data/be  byte-masked single-word store, sets dirty
//   i_fill_en/idx/tag/line  full-line install: valid=1, dirty=0
// A fill takes priority over a word write (the controller never issues both).
// -----------------------------------------------------------------------------
module l1_dcache_line_store
    import l1_dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = $clog2(NUM_LINES),
    parameter int WSEL_W         = $clog2(WORDS_PER_LINE),
    parameter int TAG_W          = 32 - IDX_W - WSEL_W - 2,
    parameter int LINE_BITS      = WORD_W * WORDS_PER_LINE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [TAG_W-1:0]     o_rd_tag,
    output logic                 o_rd_valid,
    output logic                 o_rd_dirty,
    output logic [LINE_BITS-1:0] o_rd_line,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [WSEL_W-1:0]    i_wr_word,
    input  logic [WORD_W-1:0]    i_wr_data,
    input  logic [3:0]           i_wr_be,
    input  logic                 i_fill_en,
    input  logic [IDX_W-1:0]     i_fill_idx,
    input  logic [TAG_W-1:0]     i_fill_tag,
    input  logic [LINE_BITS-1:0] i_fill_line
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_BITS-1:0] r_data [NUM_LINES];
    logic [WORD_W-1:0]    w_merged;

    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

    // Old word with the enabled byte lanes replaced by store data
    always_comb begin
        w_merged = r_data[i_wr_idx][32'(i_wr_word) * WORD_W +: WORD_W];
        for (int b = 0; b < 4; b++) begin
            if (i_wr_be[b]) begin
                w_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
            end
        end
    end

    // Status bits are the only state that reset clears
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_idx] <= 1'b1;
            r_dirty[i_fill_idx] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill_en) begin
            r_data[i_fill_idx] <= i_fill_line;
            r_tag[i_fill_idx]  <= i_fill_tag;
        end else if (i_wr_en) begin
            r_data[i_wr_idx][32'(i_wr_word) * WORD_W +: WORD_W] <= w_merged;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// -----------------------------------------------------------------------------
// l1_dcache
// Blocking, direct-mapped, write-back, write-allocate L1 data cache between
// the MEM stage and a line-wide memory.
// Optional feature: define DCACHE_STATS_EN to build the hit/miss counters;
// otherwise stat_hits and stat_misses are constant zero.
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   cpu_read, cpu_write     level requests, held by the CPU while cpu_stall
//   cpu_addr, cpu_wdata, cpu_be   byte address, lane-aligned store data, byte enables
//   cpu_rdata               load data (valid when cpu_read && !cpu_stall)
//   cpu_stall               freeze pipeline (combinational)
//   mem_req, mem_we, mem_addr, mem_wdata   line write-back / refill request
//   mem_rdata, mem_ready    refill line and one-cycle completion strobe
//   stat_hits, stat_misses  statistics counters
//   o_dbg_state             current controller state
// Memory handshake: mem_req rises with mem_we/mem_addr/mem_wdata valid and all
// of them stay stable until the single-cycle mem_ready strobe; the transaction
// completes on that edge and mem_req is low in the following cycle. mem_ready
// while no request is outstanding is ignored.
// -----------------------------------------------------------------------------
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           cpu_read,
    input  logic                           cpu_write,
    input  logic [31:0]                    cpu_addr,
    input  logic [31:0]                    cpu_wdata,
    input  logic [3:0]                     cpu_be,
    output logic [31:0]                    cpu_rdata,
    output logic                           cpu_stall,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [31:0]                    mem_addr,
    output logic [32*WORDS_PER_LINE-1:0]   mem_wdata,
    input  logic [32*WORDS_PER_LINE-1:0]   mem_rdata,
    input  logic                           mem_ready,
    output logic [STAT_W-1:0]              stat_hits,
    output logic [STAT_W-1:0]              stat_misses,
    output logic [1:0]                     o_dbg_state
);

    localparam int WSEL_W    = $clog2(WORDS_PER_LINE);
    localparam int OFF_W     = WSEL_W + 2;
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = 32 - IDX_W - OFF_W;
    localparam int LINE_BITS = WORD_W * WORDS_PER_LINE;

    logic [1:0]           r_state;
    logic                 r_mem_req;
    logic                 r_mem_we;
    logic [31:0]          r_mem_addr;
    logic [LINE_BITS-1:0] r_mem_wdata;
    logic [TAG_W-1:0]     r_miss_tag;
    logic [IDX_W-1:0]     r_miss_idx;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [WSEL_W-1:0]    w_word;
    logic [TAG_W-1:0]     w_rd_tag;
    logic                 w_rd_valid;
    logic                 w_rd_dirty;
    logic [LINE_BITS-1:0] w_rd_line;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_idle;
    logic                 w_done;
    logic                 w_miss;
    logic                 w_wr_en;
    logic                 w_fill_en;
    logic                 w_unused;

    assign w_tag    = cpu_addr[31 -: TAG_W];
    assign w_idx    = cpu_addr[OFF_W +: IDX_W];
    assign w_word   = cpu_addr[2 +: WSEL_W];
    assign w_unused = &{1'b0, cpu_addr[1:0]};

    assign w_req  = cpu_read | cpu_write;
    assign w_hit  = w_req && w_rd_valid && (w_rd_tag == w_tag);
    assign w_idle = (r_state == ST_IDLE);
    // An access completes only on a hit seen in IDLE
    assign w_done = w_idle && w_hit;
    assign w_miss = w_idle && w_req && !w_hit;

    // Write wins when both request lines are high
    assign w_wr_en   = w_done && cpu_write;
    // Only a refill that is actually on the bus may complete
    assign w_fill_en = (r_state == ST_REFILL) && r_mem_req && mem_ready;

    assign cpu_stall = !w_idle || (w_req && !w_hit);
    assign cpu_rdata = (w_done && cpu_read && !cpu_write)
                     ? w_rd_line[32'(w_word) * WORD_W +: WORD_W] : '0;

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

    l1_dcache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_store (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_rd_idx    (w_idx),
        .o_rd_tag    (w_rd_tag),
        .o_rd_valid  (w_rd_valid),
        .o_rd_dirty  (w_rd_dirty),
        .o_rd_line   (w_rd_line),
        .i_wr_en     (w_wr_en),
        .i_wr_idx    (w_idx),
        .i_wr_word   (w_word),
        .i_wr_data   (cpu_wdata),
        .i_wr_be     (cpu_be),
        .i_fill_en   (w_fill_en),
        .i_fill_idx  (r_miss_idx),
        .i_fill_tag  (r_miss_tag),
        .i_fill_line (mem_rdata)
    );

    // The miss address is captured so the transaction finishes correctly even
    // if the CPU withdraws its request (pipeline flush) mid-miss.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_miss_tag  <= '0;
            r_miss_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_miss_tag <= w_tag;
                        r_miss_idx <= w_idx;
                        r_mem_req  <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_state     <= ST_WRITEBACK;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {w_rd_tag, w_idx, {OFF_W{1'b0}}};
                            r_mem_wdata <= w_rd_line;
                        end else begin
                            r_state    <= ST_REFILL;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Drop mem_req for one cycle before the refill request
                    if (mem_ready) begin
                        r_state    <= ST_REFILL;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {r_miss_tag, r_miss_idx, {OFF_W{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [STAT_W-1:0] r_stat_hits;
    logic [STAT_W-1:0] r_stat_misses;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else begin
            if (w_done) begin
                r_stat_hits <= r_stat_hits + 1'b1;
            end
            if (w_miss) begin
                r_stat_misses <= r_stat_misses + 1'b1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
